instr_block_unpacker: RTL

INSTR_BLOCK_UNPACKER -- requirements
Module: instr_block_unpacker

---
 rtl/instr_block_unpacker.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/instr_block_unpacker.sv
// Buffers 128-bit instruction blocks in a small FIFO and emits their non-zero
// 32-bit words one per cycle, in ascending slot order, under valid/ready.
module instr_block_unpacker #(
  parameter int ID_W  = 7,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [127:0]    block_data_in,
  input  logic [ID_W-1:0] block_id_in,
  input  logic            block_valid_in,
  output logic            block_ready_out,
  output logic [31:0]     instr_out,
  output logic            instr_valid_out,
  input  logic            instr_ready_in,
  output logic [ID_W-1:0] instr_id_out,
  output logic [1:0]      instr_slot_out,
  output logic            instr_last_out,
  output logic            overflow_err_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // Handshakes: a block transfers on block_valid_in && block_ready_out, an
  // instruction on instr_valid_out && instr_ready_in, both at a rising edge;
  // the presented instruction holds while valid is high and ready is low.

  typedef enum logic {
    ST_EMPTY,
    ST_EMIT
  } state_e;

  state_e           state_q, state_d;
  logic [127:0]     data_q [DEPTH];
  logic [127:0]     data_d [DEPTH];
  logic [ID_W-1:0]  id_q   [DEPTH];
  logic [ID_W-1:0]  id_d   [DEPTH];
  logic [3:0]       mask_q [DEPTH];
  logic [3:0]       mask_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  logic [3:0]       in_mask;
  logic             accept;
  logic             wr_en;
  logic             drop;
  logic [3:0]       head_mask;
  logic [127:0]     head_data;
  logic [1:0]       head_slot;
  logic [1:0]       head_hi;
  logic [31:0]      head_word;
  logic             emit;
  logic             xfer;
  logic             pop;

  // Slot i lives in bits [(3-i)*32 +: 32]; mask bit i flags a non-zero word.
  always_comb begin
    in_mask = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      in_mask[i] = |block_data_in[(3-i)*32 +: 32];
    end
  end

  assign block_ready_out = (count_q < CNT_W'(DEPTH));
  assign accept          = block_valid_in && block_ready_out;
  assign wr_en           = accept && (|in_mask);
  assign drop            = block_valid_in && !block_ready_out;

  assign head_mask = mask_q[rd_ptr_q];
  assign head_data = data_q[rd_ptr_q];

  // Lowest set bit is presented now; highest set bit marks the block's last word.
  always_comb begin
    head_slot = 2'd0;
    head_hi   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (head_mask[i]) head_slot = 2'(i);
    end
    for (int i = 0; i < 4; i++) begin
      if (head_mask[i]) head_hi = 2'(i);
    end
  end

  always_comb begin
    head_word = 32'h0;
    case (head_slot)
      2'd0:    head_word = head_data[127:96];
      2'd1:    head_word = head_data[95:64];
      2'd2:    head_word = head_data[63:32];
      default: head_word = head_data[31:0];
    endcase
  end

  assign emit = (state_q == ST_EMIT);
  assign xfer = emit && instr_ready_in;
  assign pop  = xfer && (head_slot == head_hi);

  always_comb begin
    data_d   = data_q;
    id_d     = id_q;
    mask_d   = mask_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | drop;
    state_d  = state_q;

    // Clearing the last set bit on pop leaves the freed entry's mask at zero.
    if (xfer) begin
      mask_d[rd_ptr_q][head_slot] = 1'b0;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (wr_en) begin
      data_d[wr_ptr_q] = block_data_in;
      id_d[wr_ptr_q]   = block_id_in;
      mask_d[wr_ptr_q] = in_mask;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end

    if (wr_en && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!wr_en && pop) begin
      count_d = count_q - CNT_W'(1);
    end

    state_d = (count_d != '0) ? ST_EMIT : ST_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mask_q[i] <= 4'b0000;
      end
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      mask_q   <= mask_d;
    end
  end

  // Payload is only meaningful under a non-zero mask, so it needs no reset.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    id_q   <= id_d;
  end

  assign instr_valid_out  = emit;
  assign instr_out        = emit ? head_word : 32'h0;
  assign instr_id_out     = emit ? id_q[rd_ptr_q] : '0;
  assign instr_slot_out   = emit ? head_slot : 2'd0;
  assign instr_last_out   = emit && (head_slot == head_hi);
  assign overflow_err_out = ovf_q;

endmodule
